// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/mem_arb_prio.sv
// Data-first grant with a starvation counter that forces a fetch win
// after STARVE_LIMIT consecutive lost fetch arbitrations.
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic if_valid,
  input  logic dm_valid,
  input  logic in_idle,
  output logic grant_if,
  output logic grant_dm
);

  localparam logic [CNTW-1:0] LIMIT = CNTW'(STARVE_LIMIT);

  logic [CNTW-1:0] r_cnt;
  logic            w_force_if;

  assign w_force_if = (r_cnt == LIMIT);
  assign grant_dm   = in_idle & dm_valid & ~w_force_if;
  assign grant_if   = in_idle & if_valid & (~dm_valid | w_force_if);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (grant_if)
      r_cnt <= '0;
    else if (grant_dm && if_valid && r_cnt != LIMIT)
      r_cnt <= r_cnt + CNTW'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM
// stage; one transaction in flight, flushed fetch responses are dropped.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATAW        = 32,
  parameter int ADDRW        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNTW         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req_valid,
  input  logic [ADDRW-1:0] if_req_addr,
  output logic             if_req_ready,
  input  logic             if_flush,
  output logic             if_resp_valid,
  output logic [DATAW-1:0] if_resp_data,
  input  logic             dm_req_valid,
  input  logic             dm_req_rw,
  input  logic [1:0]       dm_req_size,
  input  logic [ADDRW-1:0] dm_req_addr,
  input  logic [DATAW-1:0] dm_req_wdata,
  output logic             dm_req_ready,
  output logic             dm_resp_valid,
  output logic [DATAW-1:0] dm_resp_data,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_rw,
  output logic [1:0]       mem_req_size,
  output logic [ADDRW-1:0] mem_req_addr,
  output logic [DATAW-1:0] mem_req_wdata,
  input  logic             mem_resp_valid,
  input  logic [DATAW-1:0] mem_resp_data,
  output logic             busy,
  output logic             owner
);

  arb_state_t       r_state;
  logic             r_owner;
  logic             r_flush_pend;
  logic             r_rw;
  logic [1:0]       r_size;
  logic [ADDRW-1:0] r_addr;
  logic [DATAW-1:0] r_wdata;
  logic [DATAW-1:0] r_if_data;
  logic [DATAW-1:0] r_dm_data;
  logic             w_idle;
  logic             w_grant_if;
  logic             w_grant_dm;

  assign w_idle = (r_state == IDLE);

  mem_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNTW         (CNTW)
  ) u_prio (
    .clock    (clock),
    .reset    (reset),
    .if_valid (if_req_valid),
    .dm_valid (dm_req_valid),
    .in_idle  (w_idle),
    .grant_if (w_grant_if),
    .grant_dm (w_grant_dm)
  );

  assign if_req_ready  = w_grant_if;
  assign dm_req_ready  = w_grant_dm;
  assign mem_req_valid = (r_state == ISSUE);
  assign mem_req_rw    = r_rw;
  assign mem_req_size  = r_size;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign busy          = ~w_idle;
  assign owner         = r_owner;
  assign if_resp_data  = r_if_data;
  assign dm_resp_data  = r_dm_data;

  // Same-cycle flush must also suppress the pulse, so the valids stay combinational.
  assign if_resp_valid = (r_state == RESP) & (r_owner == OWN_IF) & ~r_flush_pend & ~if_flush;
  assign dm_resp_valid = (r_state == RESP) & (r_owner == OWN_DM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_IF;
      r_flush_pend <= 1'b0;
      r_rw         <= 1'b0;
      r_size       <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_if_data    <= '0;
      r_dm_data    <= '0;
    end else begin
      if (!w_idle && r_owner == OWN_IF && if_flush)
        r_flush_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_grant_dm) begin
            r_owner <= OWN_DM;
            r_rw    <= dm_req_rw;
            r_size  <= dm_req_size;
            r_addr  <= dm_req_addr;
            r_wdata <= dm_req_wdata;
            r_state <= ISSUE;
          end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_rw    <= 1'b0;
            r_size  <= SZ_W;
            r_addr  <= if_req_addr;
            r_wdata <= '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: if (mem_req_ready) r_state <= WAIT;
        WAIT: begin
          if (mem_resp_valid) begin
            if (r_owner == OWN_DM)
              r_dm_data <= r_rw ? '0 : mem_resp_data;
            else
              r_if_data <= mem_resp_data;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_flush_pend <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the fetch path (instruction reads) and the MEM stage (data loads/stores) of the 5-stage RV32 pipeline.
- Each requester has a valid/ready request channel and a one-cycle response pulse.
- Data has priority; a starvation counter guarantees fetch progress.
- Only one memory transaction is outstanding at a time. Fetch responses are dropped when the pipeline flushes on a taken branch.

Parameters:
- DATAW, 32, data width.
- ADDRW, 32, address width.
- STARVE_LIMIT, 4, consecutive lost fetch arbitrations before fetch is forced to win (>=1).
- CNTW, $clog2(STARVE_LIMIT+1), starvation counter width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_addr  in  ADDRW  fetch address (PC)
- if_req_ready  out  1  fetch request accepted this cycle
- if_flush  in  1  discard any in-flight fetch response (branch taken)
- if_resp_valid  out  1  one-cycle fetch data pulse
- if_resp_data  out  DATAW  instruction word
- dm_req_valid  in  1  data request
- dm_req_rw  in  1  1 = store, 0 = load
- dm_req_size  in  2  funct3[1:0] access size
- dm_req_addr  in  ADDRW  data address
- dm_req_wdata  in  DATAW  store data
- dm_req_ready  out  1  data request accepted this cycle
- dm_resp_valid  out  1  one-cycle pulse; load data or store acknowledge
- dm_resp_data  out  DATAW  load data; 0 for stores
- mem_req_valid  out  1  request to backing memory
- mem_req_ready  in  1  memory accepts request
- mem_req_rw, mem_req_size, mem_req_addr, mem_req_wdata  out  1/2/ADDRW/DATAW  latched request fields
- mem_resp_valid  in  1  memory response strobe
- mem_resp_data  in  DATAW  memory read data
- busy  out  1  state != IDLE
- owner  out  1  0 = fetch, 1 = data; owner of current or last transaction

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs, latched request fields, owner, flush-pending flag and starve counter clear to 0. A transaction in flight is abandoned; the backing memory is reset on the same signal.
- States:
  - IDLE: arbitrate and accept.
  - ISSUE: mem_req_valid=1 until mem_req_ready.
  - WAIT: wait for mem_resp_valid.
  - RESP: drive the response pulse.
- Ready outputs are combinational and nonzero only in IDLE:
  - dm_req_ready = dm_req_valid & !force_if.
  - if_req_ready = if_req_valid & (!dm_req_valid | force_if).
  - force_if = (starve_cnt == STARVE_LIMIT).
- IDLE with an accepted request: latch the fields (fetch uses rw=0, size=2'b10, wdata=0), set owner, go to ISSUE next cycle.
- ISSUE: hold every mem_req_* field stable while mem_req_valid is high. On mem_req_ready, go to WAIT. mem_resp_valid is ignored in ISSUE.
- WAIT: on mem_resp_valid, register mem_resp_data and go to RESP.
- RESP: pulse exactly one of if_resp_valid or dm_resp_valid for one cycle, then IDLE. Response data is held until the next response. Stores return dm_resp_data=0.
- Minimum latency (memory ready immediately, responds the cycle after acceptance): request accepted at cycle N, response pulse at N+3. Back-to-back rate is one transaction per 4 cycles.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) in an IDLE cycle where both requesters are valid and data wins.
  - Clears when fetch is granted.
  - Unchanged otherwise.
- Flush:
  - if_flush in any non-IDLE state with owner=fetch sets flush_pend.
  - In RESP with flush_pend, or with if_flush high that cycle, if_resp_valid stays 0.
  - flush_pend clears on returning to IDLE.
  - if_flush in IDLE has no effect; the requester deasserts if_req_valid itself.
  - if_flush never affects data transactions.
- Requester valid dropping in IDLE before acceptance: no effect. Valid changes after acceptance are ignored.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3.
  - owner constants OWN_IF=1'b0, OWN_DM=1'b1.
  - access-size constants SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
- One sub-module, mem_arb_prio: the combinational grant plus the registered starve counter (clock, reset, both valids, in_idle -> grant_if, grant_dm).

Test Plan:
- Fetch-only read of 0x01000000; memory ready immediately and responds with 0x00000013 the next cycle -> if_req_ready at N, mem_req_valid at N+1, if_resp_valid=1 with data 0x00000013 at N+3, busy low at N+4.
- Both valid every idle cycle, STARVE_LIMIT=4 -> data granted 4 times, fetch granted on the 5th arbitration, counter back to 0 afterwards.
- Store addr 0x01000100, wdata 0xDEADBEEF, size 2'b00; memory holds mem_req_ready low 3 cycles -> mem_req_* stable for all 4 ISSUE cycles, dm_resp_valid pulse with data 0.
- Fetch outstanding, if_flush pulsed in WAIT -> no if_resp_valid. A following fetch returns normally with its own data.
- reset asserted asynchronously mid-WAIT -> busy, mem_req_valid and both resp_valid go to 0 immediately. The next request after deassertion completes normally at N+3.
